// File: rtl/ram_sp_be_clr.sv
// ram_sp_be_clr: single-port synchronous RAM with byte enables, 1/2-cycle read latency,
// post-reset clear sweep (busy) and an error pulse for rejected requests.
module ram_sp_be_clr #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int READ_LATENCY = 1,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    read_enable,
    input  logic                    write_enable,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [ADDR_WIDTH-1:0]   address,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    read_valid,
    output logic                    busy,
    output logic                    error
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d, data_out_q, data_out_d;
    logic                    rd_v_q, rd_v_d, read_valid_q, read_valid_d, error_q, error_d;
    logic                    in_range, rd_ok, wr_ok, mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata, mem_rdata;
    logic [NB-1:0]           mem_be;

    always_comb begin
        in_range     = {1'b0, address} < DEPTH_X;
        rd_ok        = state_q == IDLE && read_enable && !write_enable && in_range;
        wr_ok        = state_q == IDLE && write_enable && !read_enable && in_range;
        error_d      = (read_enable || write_enable) && !rd_ok && !wr_ok;
        mem_we       = state_q == CLEAR || wr_ok;
        mem_addr     = state_q == CLEAR ? cnt_q : address;
        mem_wdata    = state_q == CLEAR ? CLEAR_VALUE : data_in;
        mem_be       = state_q == CLEAR ? '1 : byte_en;
        mem_rdata    = rd_ok ? mem[address] : rd_data_q;
        cnt_d        = state_q == CLEAR ? cnt_q + 1'b1 : cnt_q;
        state_d      = state_q == CLEAR && cnt_q == LAST ? IDLE : state_q;
        rd_v_d       = rd_ok;
        rd_data_d    = mem_rdata;
        // Latency 2 retimes the first stage; latency 1 loads data_out straight from the array.
        read_valid_d = READ_LATENCY == 2 ? rd_v_q : rd_ok;
        data_out_d   = READ_LATENCY == 2 ? (rd_v_q ? rd_data_q : data_out_q)
                                         : (rd_ok ? mem_rdata : data_out_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt_q        <= '0;
            rd_v_q       <= 1'b0;
            rd_data_q    <= '0;
            data_out_q   <= '0;
            read_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_v_q       <= rd_v_d;
            rd_data_q    <= rd_data_d;
            data_out_q   <= data_out_d;
            read_valid_q <= read_valid_d;
            error_q      <= error_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && mem_we)
            for (int i = 0; i < NB; i++)
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    assign data_out   = data_out_q;
    assign read_valid = read_valid_q;
    assign busy       = state_q == CLEAR;
    assign error      = error_q;
endmodule

// File: tb/tb_ram_sp_be_clr.sv
// tb_ram_sp_be_clr: scoreboard bench for an 8x256 latency-1 RAM and a 32x200 latency-2 RAM
// sharing clock and reset; expected reads come from a bench-side memory model.
module tb_ram_sp_be_clr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  a_din = '0, a_addr = '0, a_dout;
    logic        a_re = 0, a_we = 0, a_rv, a_busy, a_err;
    logic [0:0]  a_be = '0;
    logic [31:0] b_din = '0, b_dout;
    logic [7:0]  b_addr = '0;
    logic        b_re = 0, b_we = 0, b_rv, b_busy, b_err;
    logic [3:0]  b_be = '0;

    ram_sp_be_clr dut_a (
        .clock(clk), .reset(rst), .data_in(a_din), .read_enable(a_re), .write_enable(a_we),
        .byte_en(a_be), .address(a_addr), .data_out(a_dout), .read_valid(a_rv),
        .busy(a_busy), .error(a_err)
    );

    ram_sp_be_clr #(.DATA_WIDTH(32), .DEPTH(200), .ADDR_WIDTH(8), .READ_LATENCY(2)) dut_b (
        .clock(clk), .reset(rst), .data_in(b_din), .read_enable(b_re), .write_enable(b_we),
        .byte_en(b_be), .address(b_addr), .data_out(b_dout), .read_valid(b_rv),
        .busy(b_busy), .error(b_err)
    );

    typedef struct { logic [31:0] d; int due; } exp_t;
    exp_t qa[$], qb[$];
    logic [7:0]  ma [256];
    logic [31:0] mb [200];
    logic exp_err_a = 0, exp_err_b = 0;
    int cyc = 0, total = 0, bad = 0, na, nb;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        a_we = 0; a_re = 0; b_we = 0; b_re = 0;
        exp_err_a = 0; exp_err_b = 0;
    endtask

    task automatic op_a(bit we, bit re, int addr, logic [7:0] d);
        bit legal;
        a_we = we; a_re = re; a_addr = addr[7:0]; a_din = d; a_be = 1'b1;
        legal = !a_busy && (we ^ re) && addr < 256;
        exp_err_a = (we | re) && !legal;
        if (legal && we) ma[addr] = d;
        if (legal && re) qa.push_back('{{24'b0, ma[addr]}, cyc + 1});
    endtask

    task automatic op_b(bit we, bit re, int addr, logic [31:0] d, logic [3:0] be);
        bit legal;
        b_we = we; b_re = re; b_addr = addr[7:0]; b_din = d; b_be = be;
        legal = !b_busy && (we ^ re) && addr < 200;
        exp_err_b = (we | re) && !legal;
        if (legal && we)
            for (int i = 0; i < 4; i++) if (be[i]) mb[addr][8*i +: 8] = d[8*i +: 8];
        if (legal && re) qb.push_back('{mb[addr], cyc + 2});
    endtask

    task automatic clear_models();
        foreach (ma[i]) ma[i] = '0;
        foreach (mb[i]) mb[i] = '0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        check("a_err", a_err, exp_err_a);
        check("b_err", b_err, exp_err_b);
        if (a_rv) begin
            if (qa.size() == 0) check("a_spurious_rv", a_rv, 0);
            else begin
                e = qa.pop_front();
                check("a_data", a_dout, e.d);
                check("a_lat", cyc, e.due);
            end
        end else if (qa.size() > 0 && qa[0].due <= cyc) begin
            check("a_missing_rv", a_rv, 1);
            void'(qa.pop_front());
        end
        if (b_rv) begin
            if (qb.size() == 0) check("b_spurious_rv", b_rv, 0);
            else begin
                e = qb.pop_front();
                check("b_data", b_dout, e.d);
                check("b_lat", cyc, e.due);
            end
        end else if (qb.size() > 0 && qb[0].due <= cyc) begin
            check("b_missing_rv", b_rv, 1);
            void'(qb.pop_front());
        end
    end

    initial begin
        clear_models();
        tick();
        tick();
        check("a_busy_rst", a_busy, 1);
        check("b_busy_rst", b_busy, 1);
        check("a_dout_rst", a_dout, 0);
        check("b_dout_rst", b_dout, 0);
        check("a_rv_rst", a_rv, 0);
        rst = 0;
        na = 0; nb = 0;
        for (int i = 0; i < 400; i++) begin
            if (a_busy) na++;
            if (b_busy) nb++;
            tick();
        end
        check("a_busy_len", na, 256);
        check("b_busy_len", nb, 200);

        tick(); op_a(0, 1, 'h00, 0); op_b(0, 1, 0, 0, 0);
        tick(); op_a(0, 1, 'h7F, 0); op_b(0, 1, 199, 0, 0);
        tick(); op_a(0, 1, 'hFF, 0);
        repeat (4) tick();

        tick(); op_a(1, 0, 'h10, 'hA5); op_b(1, 0, 'h10, 32'h0000_00A5, 4'hF);
        tick(); op_a(0, 1, 'h10, 0);    op_b(0, 1, 'h10, 0, 0);
        repeat (4) tick();

        tick(); op_b(1, 0, 3, 32'h1122_3344, 4'b1111);
        tick(); op_b(1, 0, 3, 32'hAABB_CCDD, 4'b0101);
        tick(); op_b(0, 1, 3, 0, 0);
        tick(); op_b(1, 0, 3, 32'hFFFF_FFFF, 4'b0000);
        tick(); op_b(0, 1, 3, 0, 0);
        repeat (4) tick();

        tick(); op_a(1, 0, 5, 'h3C);
        tick(); op_a(0, 1, 5, 0);
        repeat (3) tick();
        tick(); op_a(1, 1, 5, 'hFF); op_b(1, 1, 5, 32'h1234_5678, 4'hF);
        tick();
        tick();
        check("a_hold", a_dout, 8'h3C);
        tick(); op_a(0, 1, 5, 0);
        repeat (4) tick();

        tick(); op_b(1, 0, 'hC8, 32'hDEAD_BEEF, 4'hF);
        tick(); op_b(0, 1, 'hC8, 0, 0);
        tick(); op_b(1, 0, 199, 32'hCAFE_F00D, 4'hF);
        tick(); op_b(0, 1, 199, 0, 0);
        repeat (4) tick();

        for (int i = 0; i < 16; i++) begin
            tick(); op_b(1, 0, i, 32'h5A5A_0000 ^ (i * 32'h0101_0101), 4'hF);
        end
        for (int i = 0; i < 16; i++) begin
            tick(); op_b(0, 1, i, 0, 0);
        end
        repeat (5) tick();

        rst = 1;
        tick();
        rst = 0;
        clear_models();
        repeat (100) tick();
        rst = 1;
        tick();
        rst = 0;
        na = 0;
        for (int i = 0; i < 400; i++) begin
            if (a_busy) na++;
            tick();
            if (i == 10) op_a(0, 1, 'h10, 0);
        end
        check("a_busy_restart", na, 256);
        tick(); op_a(0, 1, 'h10, 0); op_b(0, 1, 3, 0, 0);
        tick(); op_a(0, 1, 5, 0);
        repeat (5) tick();
        check("a_q_empty", qa.size(), 0);
        check("b_q_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_sp_be_clr.md
Name: ram_sp_be_clr

Overview:
Parametrised single-port synchronous RAM. It is the next generation of the team's 8-bit x 256 single-port RAM.
- Adds configurable width, depth and read latency.
- Adds per-byte write enables and a read-valid strobe.
- Adds a post-reset memory-clear sequencer with busy flag, and an error pulse for illegal accesses.
- Sits behind a simple enable-based master; the same UVM environment verifies it.

Parameters:
DATA_WIDTH, 8, data bits per word; must be a multiple of 8
DEPTH, 256, number of words
ADDR_WIDTH, 8, address bits; must satisfy 2**ADDR_WIDTH >= DEPTH
READ_LATENCY, 1, cycles from read request to data_out/read_valid; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = sweep memory to CLEAR_VALUE after reset; 0 = no sweep
CLEAR_VALUE, 0, word written to every location during the sweep

Ports:
clock  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  DATA_WIDTH  write data
read_enable  input  1  read request
write_enable  input  1  write request
byte_en  input  DATA_WIDTH/8  per-byte write mask; bit i covers data_in[8i+7:8i]
address  input  ADDR_WIDTH  word address
data_out  output  DATA_WIDTH  registered read data; holds between reads
read_valid  output  1  one-cycle pulse, coincident with new data_out
busy  output  1  high while the clear sweep runs; accesses ignored
error  output  1  one-cycle pulse on a rejected request

Behaviour:
Reset (reset=1 at clock edge):
- data_out=0, read_valid=0, error=0.
- Read pipeline flushed.
- Clear counter=0. State=CLEAR if CLEAR_ON_RESET, else IDLE.
- busy=1 while in CLEAR, including during reset.
- No memory writes while reset=1.

State machine:
- CLEAR: each cycle, mem[cnt] <= CLEAR_VALUE and cnt++. After writing DEPTH-1, go to IDLE. The sweep takes exactly DEPTH cycles after reset deasserts.
- busy is 1 in CLEAR and falls on the edge that enters IDLE.
- IDLE: services requests. No exit except reset.
- Reset mid-sweep restarts the sweep at 0.

Request classification, evaluated at each edge in IDLE:
- write_enable=1, read_enable=0, address<DEPTH: mem[address] byte i <= data_in byte i for each set byte_en[i]; other bytes unchanged. byte_en=0 is a legal no-op.
- read_enable=1, write_enable=0, address<DEPTH: read accepted.
  - READ_LATENCY=1: data_out and read_valid update on the next edge.
  - READ_LATENCY=2: one extra register stage.
  - Fully pipelined: back-to-back reads give back-to-back read_valid pulses, in order.
- Both enables high: no memory access; error=1 for one cycle.
- Any enable with address>=DEPTH: no access; error=1.
- Any enable while busy: ignored; error=1.
- No enable: nothing happens; error=0.

Read/write interaction:
- Write at cycle N followed by a read of the same address at N+1 returns the new data.
- A read and a write cannot coincide (single port).

Output behaviour:
- data_out never goes to Z.
- data_out holds its last value when no read completes.
- read_valid=0 except on completing reads.

Test Plan:
- Reset 2 cycles, DEPTH=256, CLEAR_ON_RESET=1 -> busy=1 for 256 cycles after reset falls. Then read addr 0x00, 0x7F, 0xFF -> data_out=0x00, one read_valid pulse each.
- Write 0xA5 to addr 0x10, then read 0x10 next cycle -> data_out=0xA5 after 1 cycle (LATENCY=1); repeat with LATENCY=2 -> data after 2 cycles.
- DATA_WIDTH=32: write 0x11223344 to addr 3 with byte_en=1111, then write 0xAABBCCDD with byte_en=0101 -> read returns 0x11BB33DD.
- read_enable=write_enable=1 at addr 5 holding 0x3C -> error pulse 1 cycle, mem[5] still 0x3C, read_valid=0, data_out unchanged.
- Reset asserted at sweep count 100 -> sweep restarts; busy lasts a full 256 cycles from the new release. A read during busy -> error=1, no read_valid.
- DEPTH=200, ADDR_WIDTH=8: write at address 0xC8 -> error=1, no memory change. 16 back-to-back reads of addrs 0..15 with LATENCY=2 -> 16 consecutive read_valid pulses with in-order data.
